// File: rtl/ex_muldiv_ctrl_if.sv
// Execute-stage <-> mul/div sequencer handshake bundle.
interface ex_muldiv_ctrl_if #(
    parameter int WIDTH = 24
);
    logic             iw_start;
    logic [1:0]       iw_op;
    logic [WIDTH-1:0] iw_a;
    logic [WIDTH-1:0] iw_b;
    logic             iw_flush;
    logic             ow_busy;
    logic             ow_stall;
    logic             ow_done;
    logic [WIDTH-1:0] ow_result;
    logic             ow_fl_z;
    logic             ow_fl_v;

    modport master (
        output iw_start, iw_op, iw_a, iw_b, iw_flush,
        input  ow_busy, ow_stall, ow_done, ow_result, ow_fl_z, ow_fl_v
    );

    modport slave (
        input  iw_start, iw_op, iw_a, iw_b, iw_flush,
        output ow_busy, ow_stall, ow_done, ow_result, ow_fl_z, ow_fl_v
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle unsigned multiply/divide sequencer beside the execute stage.
// One shift-add (MUL) or restoring-division (DIV) step per clock, WIDTH steps.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request
// RUN   | iterating, one step per clock, pipeline stalled
// DONE  | result registered, ow_done high; may accept back-to-back
module ex_muldiv_ctrl #(
    parameter int WIDTH = 24,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input logic              iw_clk,
    input logic              iw_rst,
    ex_muldiv_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;        // multiplicand
    logic [WIDTH-1:0]     b_q;        // divisor
    logic [2*WIDTH-1:0]   prod_q;     // {accumulator, multiplier}
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quot_q;     // dividend shifts out as quotient shifts in
    logic [CNTW-1:0]      cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     result_q;
    logic                 z_q;
    logic                 v_q;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quot_d;
    logic [WIDTH-1:0]     res_d;
    logic [WIDTH-1:0]     div0_res;
    logic                 idle_or_done;
    logic                 accept;
    logic                 div0;
    logic                 last_step;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept       = idle_or_done && bus.iw_start && !bus.iw_flush;
    assign div0         = bus.iw_op[1] && (bus.iw_b == '0);
    assign div0_res     = bus.iw_op[0] ? bus.iw_a : '1;
    assign last_step    = (cnt_q == CNTW'(WIDTH - 1));

    // One datapath step: shift-add multiply and restoring divide, plus final result select.
    always_comb begin
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
        // Shifted partial remainder needs one extra bit before the compare.
        rem_sh  = {rem_q, quot_q[WIDTH-1]};
        if (rem_sh >= {1'b0, b_q}) begin
            rem_d  = WIDTH'(rem_sh - {1'b0, b_q});
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        case (op_q)
            2'b00:   res_d = prod_d[WIDTH-1:0];
            2'b01:   res_d = prod_d[2*WIDTH-1:WIDTH];
            2'b10:   res_d = quot_d;
            default: res_d = rem_d;
        endcase
    end

    // Sequencer FSM, step counter, operand/partial registers and registered outputs.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q   <= bus.iw_op;
                        a_q    <= bus.iw_a;
                        b_q    <= bus.iw_b;
                        prod_q <= {{WIDTH{1'b0}}, bus.iw_b};
                        rem_q  <= '0;
                        quot_q <= bus.iw_a;
                        cnt_q  <= '0;
                        if (div0) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= div0_res;
                            z_q      <= (div0_res == '0);
                            v_q      <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.iw_flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (op_q[1]) begin
                            rem_q  <= rem_d;
                            quot_q <= quot_d;
                        end else begin
                            prod_q <= prod_d;
                        end
                        cnt_q <= cnt_q + CNTW'(1);
                        if (last_step) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= res_d;
                            z_q      <= (res_d == '0);
                            v_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ow_stall  = ((state_q == S_RUN) && !bus.iw_flush) ||
                           (idle_or_done && bus.iw_start && !bus.iw_flush && !div0);
    assign bus.ow_busy   = busy_q;
    assign bus.ow_done   = done_q;
    assign bus.ow_result = result_q;
    assign bus.ow_fl_z   = z_q;
    assign bus.ow_fl_v   = v_q;

endmodule
